// File: rtl/mult_fub_pkg.sv
// Shared definitions for the multiplier functional-unit buffer: widths, entry type and
// the branch-stack one-hot helper.
package sys_defs;

    localparam int DATA_W    = 64;
    localparam int PREG_W    = 6;
    localparam int BMASK_W   = 4;
    localparam int BS_PTR_W  = 2;
    localparam int FUB_DEPTH = 4;

    typedef logic [DATA_W-1:0]             DATA;
    typedef logic [PREG_W-1:0]             PHYS_REG;
    typedef logic [BMASK_W-1:0]            B_MASK;
    typedef logic [BS_PTR_W-1:0]           BS_PTR;
    typedef logic [$clog2(FUB_DEPTH)-1:0]  FUB_PTR;

    typedef struct packed {
        logic    valid;
        DATA     result;
        PHYS_REG tagDest;
        B_MASK   bmask;
    } FUB_ENTRY;

    function automatic B_MASK bs_onehot(input BS_PTR p);
        return B_MASK'(1) << p;
    endfunction

endpackage

// File: rtl/mult_fub_if.sv
// Multiplier-to-FUB and FUB-to-CDB signal bundle; master is the multiplier/CDB side,
// slave is the buffer.
interface mult_fub_if;
    import sys_defs::*;

    logic    mult_done;
    DATA     mult_result;
    PHYS_REG mult_tagDest;
    B_MASK   mult_bmask;
    logic    fub_mult_busy;
    logic    cdb_grant;
    logic    fub_valid;
    DATA     fub_result;
    PHYS_REG fub_tagDest;
    B_MASK   fub_bmask;

    modport master (
        output mult_done, mult_result, mult_tagDest, mult_bmask, cdb_grant,
        input  fub_mult_busy, fub_valid, fub_result, fub_tagDest, fub_bmask
    );

    modport slave (
        input  mult_done, mult_result, mult_tagDest, mult_bmask, cdb_grant,
        output fub_mult_busy, fub_valid, fub_result, fub_tagDest, fub_bmask
    );

endinterface

// File: rtl/mult_fub_bmask_update.sv
// Applies a branch resolution to one entry: a mispredict squashes entries that depend on
// the resolved slot, and any resolution clears that slot's bit.
module fub_bmask_update
    import sys_defs::*;
(
    input  FUB_ENTRY entry_i,
    input  logic     br_branch_resolved_i,
    input  logic     br_pred_wrong_i,
    input  BS_PTR    br_bs_ptr_i,
    output FUB_ENTRY entry_o
);

    B_MASK sel;

    always_comb begin
        sel     = bs_onehot(br_bs_ptr_i);
        entry_o = entry_i;
        if (br_branch_resolved_i && ((entry_i.bmask & sel) != '0)) begin
            entry_o.bmask = entry_i.bmask & ~sel;
            if (br_pred_wrong_i) begin
                entry_o.valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_fub.sv
// Circular result buffer between the multiplier and the CDB, with branch squash support.
// Optional same-cycle bypass of an empty buffer is enabled by defining FUB_BYPASS_EN.
module mult_fub
    import sys_defs::*;
#(
    parameter int FUB_DEPTH = sys_defs::FUB_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      br_pred_wrong,
    input  logic      br_branch_resolved,
    input  BS_PTR     br_bs_ptr,
    mult_fub_if.slave bus
);

    localparam int PTR_W = $clog2(FUB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FUB_DEPTH);

    FUB_ENTRY         mem_q   [FUB_DEPTH];
    FUB_ENTRY         mem_d   [FUB_DEPTH];
    FUB_ENTRY         mem_upd [FUB_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    FUB_ENTRY         push_raw, push_upd, head_ent;
    logic             push_req, stored_vld, do_pop, do_retire, deq, wr_en;
`ifdef FUB_BYPASS_EN
    logic             byp_vld, byp_taken;
`endif

    // Busy depends only on registered occupancy so the multiplier never sees a grant path.
    assign bus.fub_mult_busy = (count_q == FULL);
    assign push_req          = bus.mult_done & ~bus.fub_mult_busy;

    for (genvar i = 0; i < FUB_DEPTH; i++) begin : g_upd
        fub_bmask_update u_upd (
            .entry_i              (mem_q[i]),
            .br_branch_resolved_i (br_branch_resolved),
            .br_pred_wrong_i      (br_pred_wrong),
            .br_bs_ptr_i          (br_bs_ptr),
            .entry_o              (mem_upd[i])
        );
    end

    fub_bmask_update u_push_upd (
        .entry_i              (push_raw),
        .br_branch_resolved_i (br_branch_resolved),
        .br_pred_wrong_i      (br_pred_wrong),
        .br_bs_ptr_i          (br_bs_ptr),
        .entry_o              (push_upd)
    );

    always_comb begin
        push_raw   = '{valid: 1'b1, result: bus.mult_result,
                       tagDest: bus.mult_tagDest, bmask: bus.mult_bmask};
        head_ent   = mem_q[head_q];
        stored_vld = (count_q != '0) && head_ent.valid;
        do_pop     = stored_vld && bus.cdb_grant;
        do_retire  = (count_q != '0) && !head_ent.valid;
        deq        = do_pop || do_retire;
`ifdef FUB_BYPASS_EN
        byp_vld    = (count_q == '0) && push_req && push_upd.valid;
        byp_taken  = byp_vld && bus.cdb_grant;
        wr_en      = push_req && push_upd.valid && !byp_taken;
`else
        wr_en      = push_req && push_upd.valid;
`endif

        bus.fub_valid   = stored_vld;
        bus.fub_result  = '0;
        bus.fub_tagDest = '0;
        bus.fub_bmask   = '0;
        if (stored_vld) begin
            bus.fub_result  = head_ent.result;
            bus.fub_tagDest = head_ent.tagDest;
            bus.fub_bmask   = head_ent.bmask;
        end
`ifdef FUB_BYPASS_EN
        else if (byp_vld) begin
            bus.fub_valid   = 1'b1;
            bus.fub_result  = push_raw.result;
            bus.fub_tagDest = push_raw.tagDest;
            bus.fub_bmask   = push_raw.bmask;
        end
`endif

        // Full-with-pop refuses the push, so tail never collides with a live head slot.
        mem_d = mem_upd;
        if (deq) begin
            mem_d[head_q].valid = 1'b0;
        end
        if (wr_en) begin
            mem_d[tail_q] = push_upd;
        end
        head_d  = deq   ? head_q + PTR_W'(1) : head_q;
        tail_d  = wr_en ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FUB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < FUB_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mult_fub.sv
// Scoreboard bench for mult_fub: a queue-of-slots reference model updated at each edge
// and a negedge monitor comparing every presented output against the model head.
`timescale 1ns/1ps
module tb_mult_fub;
    import sys_defs::*;

    localparam int DEPTH = 4;
    localparam int LIM   = 50;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  br_pred_wrong = 1'b0;
    logic  br_branch_resolved = 1'b0;
    BS_PTR br_bs_ptr = '0;
    int    total = 0;
    int    bad = 0;

    mult_fub_if bus ();

    mult_fub #(.FUB_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .br_pred_wrong      (br_pred_wrong),
        .br_branch_resolved (br_branch_resolved),
        .br_bs_ptr          (br_bs_ptr),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    valid;
        DATA     result;
        PHYS_REG tag;
        B_MASK   bmask;
    } slot_t;

    slot_t slots[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupied slots in arrival order; squashed slots stay until retired.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            slots.delete();
        end else begin
            bit    had, pop, push_ok, drop, byp;
            slot_t s, t;
            had     = slots.size() != 0;
            pop     = had && (!slots[0].valid || bus.cdb_grant);
            push_ok = bus.mult_done && (slots.size() < DEPTH);
            s.valid  = 1'b1;
            s.result = bus.mult_result;
            s.tag    = bus.mult_tagDest;
            s.bmask  = bus.mult_bmask;
            drop = 1'b0;
            byp  = 1'b0;
            if (br_branch_resolved) begin
                for (int i = 0; i < slots.size(); i++) begin
                    t = slots[i];
                    if (t.bmask[br_bs_ptr]) begin
                        if (br_pred_wrong) t.valid = 1'b0;
                        t.bmask[br_bs_ptr] = 1'b0;
                    end
                    slots[i] = t;
                end
                if (s.bmask[br_bs_ptr]) begin
                    if (br_pred_wrong) drop = 1'b1;
                    s.bmask[br_bs_ptr] = 1'b0;
                end
            end
`ifdef FUB_BYPASS_EN
            byp = !had && push_ok && !drop && bus.cdb_grant;
`endif
            if (pop) void'(slots.pop_front());
            if (push_ok && !drop && !byp) slots.push_back(s);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            bit      ev;
            DATA     er;
            PHYS_REG et;
            B_MASK   eb;
            ev = 1'b0; er = '0; et = '0; eb = '0;
            if (slots.size() != 0) begin
                if (slots[0].valid) begin
                    ev = 1'b1; er = slots[0].result; et = slots[0].tag; eb = slots[0].bmask;
                end
            end
`ifdef FUB_BYPASS_EN
            else if (bus.mult_done &&
                     !(br_branch_resolved && br_pred_wrong && bus.mult_bmask[br_bs_ptr])) begin
                ev = 1'b1; er = bus.mult_result; et = bus.mult_tagDest; eb = bus.mult_bmask;
            end
`endif
            chk("mon_busy",   64'(bus.fub_mult_busy), 64'(slots.size() == DEPTH));
            chk("mon_valid",  64'(bus.fub_valid), 64'(ev));
            chk("mon_tag",    64'(bus.fub_tagDest), 64'(et));
            chk("mon_result", bus.fub_result, er);
            chk("mon_bmask",  64'(bus.fub_bmask), 64'(eb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hold(input PHYS_REG tag, input B_MASK bm);
        int n;
        bus.mult_done    = 1'b1;
        bus.mult_tagDest = tag;
        bus.mult_bmask   = bm;
        bus.mult_result  = {$urandom, $urandom};
        n = 0;
        while (bus.fub_mult_busy && n < LIM) begin
            tick();
            n++;
        end
        chk("push_wait", 64'(n >= LIM), 64'(0));
        tick();
        bus.mult_done = 1'b0;
    endtask

    task automatic drain(input int cycles);
        bus.cdb_grant = 1'b1;
        repeat (cycles) tick();
        bus.cdb_grant = 1'b0;
    endtask

    initial begin
        bit acc;
        bus.mult_done = 1'b0; bus.mult_result = '0; bus.mult_tagDest = '0;
        bus.mult_bmask = '0;  bus.cdb_grant = 1'b0;
        #2;
        chk("rst_valid", 64'(bus.fub_valid), 64'(0));
        chk("rst_busy",  64'(bus.fub_mult_busy), 64'(0));
        chk("rst_data",  bus.fub_result, 64'(0));
        chk("rst_tag",   64'(bus.fub_tagDest), 64'(0));
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // In-order delivery with grant held off, then granted
        push_hold(6'd5, 4'b0000);
        push_hold(6'd6, 4'b0000);
        push_hold(6'd7, 4'b0000);
        chk("order_head_valid", 64'(bus.fub_valid), 64'(1));
        chk("order_head_tag",   64'(bus.fub_tagDest), 64'(5));
        drain(3);
        chk("order_empty", 64'(bus.fub_valid), 64'(0));

        // Fill to full, fifth result waits for a single grant
        for (int i = 0; i < DEPTH; i++) push_hold(PHYS_REG'(40 + i), 4'b0000);
        chk("full_busy", 64'(bus.fub_mult_busy), 64'(1));
        fork
            push_hold(6'd45, 4'b0000);
            begin
                repeat (3) tick();
                bus.cdb_grant = 1'b1;
                tick();
                bus.cdb_grant = 1'b0;
            end
        join
        chk("refill_busy", 64'(bus.fub_mult_busy), 64'(1));
        drain(DEPTH + 2);

        // Mispredict on slot 0 squashes two of three entries
        push_hold(6'd10, 4'b0001);
        push_hold(6'd11, 4'b0010);
        push_hold(6'd12, 4'b0001);
        br_branch_resolved = 1'b1; br_pred_wrong = 1'b1; br_bs_ptr = 2'd0;
        tick();
        br_branch_resolved = 1'b0; br_pred_wrong = 1'b0;
        chk("squash_head_hidden", 64'(bus.fub_valid), 64'(0));
        tick();
        chk("squash_survivor", 64'(bus.fub_tagDest), 64'(11));
        drain(4);

        // Correct resolve on slot 1 clears that bit only
        push_hold(6'd20, 4'b0011);
        br_branch_resolved = 1'b1; br_pred_wrong = 1'b0; br_bs_ptr = 2'd1;
        tick();
        br_branch_resolved = 1'b0;
        chk("resolve_bmask", 64'(bus.fub_bmask), 64'(1));
        drain(2);

`ifdef FUB_BYPASS_EN
        bus.mult_done = 1'b1; bus.mult_tagDest = 6'd9; bus.mult_bmask = '0;
        bus.mult_result = 64'h1234; bus.cdb_grant = 1'b1;
        #1;
        chk("bypass_valid", 64'(bus.fub_valid), 64'(1));
        chk("bypass_tag",   64'(bus.fub_tagDest), 64'(9));
        tick();
        bus.mult_done = 1'b0; bus.cdb_grant = 1'b0;
        #1;
        chk("bypass_not_stored", 64'(bus.fub_valid), 64'(0));
        tick();
`endif

        // Asynchronous reset with entries stored and a push pending
        push_hold(6'd30, 4'b0000);
        push_hold(6'd31, 4'b0000);
        push_hold(6'd32, 4'b0000);
        bus.mult_done = 1'b1; bus.mult_tagDest = 6'd33;
        #3;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(bus.fub_valid), 64'(0));
        chk("arst_busy",  64'(bus.fub_mult_busy), 64'(0));
        chk("arst_tag",   64'(bus.fub_tagDest), 64'(0));
        tick();
        bus.mult_done = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        chk("arst_no_stale", 64'(bus.fub_valid), 64'(0));

        // Randomised traffic with backpressure and branch events
        acc = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.mult_done || acc) begin
                bus.mult_done    = ($urandom_range(0, 99) < 60);
                bus.mult_tagDest = PHYS_REG'($urandom_range(0, 63));
                bus.mult_bmask   = ($urandom_range(0, 1) == 0) ? B_MASK'(0)
                                                                : B_MASK'($urandom_range(0, 15));
                bus.mult_result  = {$urandom, $urandom};
            end
            bus.cdb_grant      = ($urandom_range(0, 99) < 45);
            br_branch_resolved = ($urandom_range(0, 99) < 10);
            br_pred_wrong      = ($urandom_range(0, 99) < 40);
            br_bs_ptr          = BS_PTR'($urandom_range(0, 3));
            acc = bus.mult_done && !bus.fub_mult_busy;
            tick();
        end
        bus.mult_done = 1'b0;
        br_branch_resolved = 1'b0;
        br_pred_wrong = 1'b0;
        drain(2 * DEPTH + 2);
        chk("final_empty", 64'(bus.fub_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_fub.md
MULT_FUB -- requirements
Module: mult_fub

Interface
REQ-001 SHALL have parameter FUB_DEPTH, default 4, entry count (power of two, >=2).
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have mult_done  input  1  multiplier result valid this cycle.
REQ-005 SHALL have mult_result  input  DATA(64)  product.
REQ-006 SHALL have mult_tagDest  input  PHYS_REG  destination physical register.
REQ-007 SHALL have mult_bmask  input  B_MASK  branch mask of result.
REQ-008 SHALL have cdb_grant  input  1  CDB arbiter accepts the presented head this cycle.
REQ-009 SHALL have br_pred_wrong, br_branch_resolved  input  1 each  branch resolution event.
REQ-010 SHALL have br_bs_ptr  input  BS_PTR  branch stack slot being resolved.
REQ-011 SHALL have fub_mult_busy  output  1  backpressure to multiplier; multiplier holds its result while high.
REQ-012 SHALL have fub_valid  output  1  CDB request.
REQ-013 SHALL have fub_result, fub_tagDest, fub_bmask  output  DATA/PHYS_REG/B_MASK  presented entry.

Function
REQ-014 SHALL store entries {valid, result, tagDest, bmask} in a circular buffer with head, tail pointers and occupancy count 0..FUB_DEPTH.
REQ-015 SHALL push at tail when mult_done & ~fub_mult_busy; data written next edge.
REQ-016 SHALL drive fub_mult_busy = (count == FUB_DEPTH), from registered state only (no path from cdb_grant or mult_done).
REQ-017 SHALL present head entry: fub_valid = count!=0 & head.valid; outputs head fields; zero when fub_valid low.
REQ-018 SHALL pop head (head++, count--) when fub_valid & cdb_grant; cdb_grant while fub_valid low SHALL be ignored.
REQ-019 SHALL retire an invalid (squashed) head slot automatically, one per cycle, without grant.
REQ-020 SHALL, on br_branch_resolved & br_pred_wrong, clear valid of every entry with bmask[br_bs_ptr]=1 same edge; slots stay occupied until retired by REQ-019.
REQ-021 SHALL, on br_branch_resolved, clear bmask[br_bs_ptr] in all stored entries; fub_bmask reflects the stored value (pre-clear) in that cycle.
REQ-022 SHALL drop an incoming push whose mult_bmask[br_bs_ptr]=1 during a mispredict cycle (slot not allocated); on correct resolve, store it with that bit cleared.
REQ-023 SHALL handle simultaneous push and pop/retire: count unchanged; full with pop still refuses push (busy is registered).
REQ-024 SHALL wrap head/tail modulo FUB_DEPTH.
REQ-025 Latency without bypass: push at edge N -> fub_valid in cycle N+1 if buffer was empty.

Reset
REQ-026 SHALL on reset: head=tail=count=0, all valid=0, fub_valid=0, fub_mult_busy=0, data outputs 0; reset mid-operation discards all entries, including an in-flight push that cycle.

Configuration
REQ-027 SHALL support macro FUB_BYPASS_EN: when defined and buffer empty (count==0), a pushable mult_done is presented combinationally on fub_* the same cycle; if cdb_grant, it is not written.
REQ-028 Without FUB_BYPASS_EN, all results pass through storage (REQ-025); the bypass path SHALL not be present.

Structure
REQ-029 SHALL place FUB_DEPTH default, FUB_PTR typedef and FUB_ENTRY struct {valid, result, tagDest, bmask} in the shared sys_defs package.
REQ-030 SHALL implement per-entry squash/bmask-clear in sub-module fub_bmask_update (combinational, instantiated per entry and on the push path).

Verification
REQ-031 Push 3 results (tags 5,6,7), cdb_grant held low -> fub_valid=1 with tag 5; grant 3 cycles -> tags 5,6,7 in order, count 0.
REQ-032 Fill 4 entries, grant low -> fub_mult_busy=1, 5th mult_done held, not stored; one grant -> busy drops next cycle, 5th pushed.
REQ-033 Entries bmask 0b01,0b10,0b01; mispredict br_bs_ptr=0 -> only 0b10 entry reaches CDB, two squashed slots retired without grant.
REQ-034 Correct resolve br_bs_ptr=1 with stored bmask 0b11 -> fub_bmask reads 0b01 next cycle.
REQ-035 With FUB_BYPASS_EN, empty buffer, mult_done tag 9 and cdb_grant same cycle -> fub_valid=1 tag 9 that cycle, count stays 0.
REQ-036 Assert reset with 3 entries and push pending -> fub_valid=0, busy=0 immediately; no stale entry after reset release.
